// File: rtl/fft_freq_mac_pkg.sv
// Shared types for the frequency-domain MAC: Q-format complex samples, 4x4 tiles
// and the bin-level complex multiply used by the product stage.
package fft_freq_mac_pkg;

  localparam int FRAC_DEFAULT = 16;

  typedef struct packed {
    logic signed [31:0] r;
    logic signed [31:0] i;
  } complex_t;

  typedef complex_t [0:3][0:3] tile_t;

  typedef logic signed [63:0] prod_t;

  // Full 64-bit products, arithmetic rescale by frac, then keep the low 32 bits.
  function automatic complex_t cmul(input complex_t a, input complex_t b, input int frac);
    prod_t    ar;
    prod_t    ai;
    prod_t    br;
    prod_t    bi;
    prod_t    p_re;
    prod_t    p_im;
    complex_t p;
    ar   = {{32{a.r[31]}}, a.r};
    ai   = {{32{a.i[31]}}, a.i};
    br   = {{32{b.r[31]}}, b.r};
    bi   = {{32{b.i[31]}}, b.i};
    p_re = (ar * br - ai * bi) >>> frac;
    p_im = (ar * bi + ai * br) >>> frac;
    p.r  = p_re[31:0];
    p.i  = p_im[31:0];
    return p;
  endfunction

endpackage

// File: rtl/fft_cmul_q.sv
// Registered single-bin complex multiplier, one cycle of latency.
module fft_cmul_q
  import fft_freq_mac_pkg::*;
#(
  parameter int FRAC = FRAC_DEFAULT
) (
  input  logic     clk_i,
  input  logic     rst_n_i,
  input  complex_t a_i,
  input  complex_t b_i,
  output complex_t p_o
);

  complex_t p_d;
  complex_t p_q;

  always_comb begin
    p_d = cmul(a_i, b_i, FRAC);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      p_q <= '0;
    end else begin
      p_q <= p_d;
    end
  end

  assign p_o = p_q;

endmodule

// File: rtl/fft_freq_mac.sv
// Per-channel bin-wise multiply of FFT tiles with stored kernel spectra,
// accumulated over a channel group and handed to the IFFT with next/next_out.
module fft_freq_mac
  import fft_freq_mac_pkg::*;
#(
  parameter int MAX_CH = 16,
  parameter int FRAC   = FRAC_DEFAULT
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      next,
  input  tile_t                     in,
  input  logic [$clog2(MAX_CH):0]   cfg_num_ch,
  input  logic                      k_wr_en,
  input  logic [$clog2(MAX_CH)-1:0] k_wr_addr,
  input  tile_t                     k_wr_data,
  output logic                      next_out,
  output tile_t                     out,
  output logic                      busy
);

  localparam int AW = $clog2(MAX_CH);
  localparam int NW = AW + 1;

  tile_t kbuf_q [MAX_CH];

  logic          pend_q;
  logic [AW-1:0] ch_cnt_q, ch_cnt_d;
  logic [NW-1:0] n_q, n_d;
  logic [NW-1:0] n_cfg;
  logic [NW-1:0] n_eff;
  logic          first_cap;
  logic          last_cap;

  logic          v1_q, first1_q, last1_q;
  tile_t         a1_q, b1_q;
  logic          v2_q, first2_q, last2_q;
  logic          nout_q;
  tile_t         prod;
  tile_t         sum;
  tile_t         acc_q;
  tile_t         out_q;

  // Kernel store has no reset; a same-edge write is seen by the next read only.
  always_ff @(posedge clk) begin
    if (k_wr_en) begin
      kbuf_q[k_wr_addr] <= k_wr_data;
    end
  end

  always_comb begin
    n_cfg = cfg_num_ch;
    if (cfg_num_ch == '0) begin
      n_cfg = NW'(1);
    end else if (cfg_num_ch > NW'(MAX_CH)) begin
      n_cfg = NW'(MAX_CH);
    end
  end

  always_comb begin
    first_cap = (ch_cnt_q == '0);
    n_eff     = first_cap ? n_cfg : n_q;
    last_cap  = ({1'b0, ch_cnt_q} == (n_eff - NW'(1)));
    ch_cnt_d  = ch_cnt_q;
    n_d       = n_q;
    if (pend_q) begin
      ch_cnt_d = last_cap ? '0 : ch_cnt_q + AW'(1);
      if (first_cap) begin
        n_d = n_cfg;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend_q   <= 1'b0;
      ch_cnt_q <= '0;
      n_q      <= NW'(1);
      v1_q     <= 1'b0;
      first1_q <= 1'b0;
      last1_q  <= 1'b0;
      a1_q     <= '0;
      b1_q     <= '0;
    end else begin
      pend_q   <= next;
      ch_cnt_q <= ch_cnt_d;
      n_q      <= n_d;
      v1_q     <= pend_q;
      if (pend_q) begin
        first1_q <= first_cap;
        last1_q  <= last_cap;
        a1_q     <= in;
        b1_q     <= kbuf_q[ch_cnt_q];
      end
    end
  end

  for (genvar j = 0; j < 4; j++) begin : g_row
    for (genvar k = 0; k < 4; k++) begin : g_col
      fft_cmul_q #(.FRAC(FRAC)) u_cmul (
        .clk_i   (clk),
        .rst_n_i (reset),
        .a_i     (a1_q[j][k]),
        .b_i     (b1_q[j][k]),
        .p_o     (prod[j][k])
      );
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      v2_q     <= 1'b0;
      first2_q <= 1'b0;
      last2_q  <= 1'b0;
      nout_q   <= 1'b0;
    end else begin
      v2_q     <= v1_q;
      first2_q <= first1_q;
      last2_q  <= last1_q;
      nout_q   <= v1_q & last1_q;
    end
  end

  // The first tile of a group ignores the accumulator, so groups can abut.
  always_comb begin
    sum = '0;
    for (int j = 0; j < 4; j++) begin
      for (int k = 0; k < 4; k++) begin
        sum[j][k].r = (first2_q ? 32'sd0 : acc_q[j][k].r) + prod[j][k].r;
        sum[j][k].i = (first2_q ? 32'sd0 : acc_q[j][k].i) + prod[j][k].i;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_q <= '0;
      out_q <= '0;
    end else if (v2_q) begin
      acc_q <= sum;
      if (last2_q) begin
        out_q <= sum;
      end
    end
  end

  assign next_out = nout_q;
  assign out      = out_q;
  assign busy     = (ch_cnt_q != '0) | v1_q | v2_q;

endmodule
